packer_ancho_param: RTL

//   Parametrised narrow-to-wide word packer, successor of the fixed 8b->32b converter.

---
 rtl/packer_ancho_param_if.sv | 26 ++
 rtl/packer_ancho_param.sv | 86 ++++++++
 2 files changed

// File: rtl/packer_ancho_param_if.sv
// Handshake and data bundle between the byte-stream source, the packer and the wide sink.
interface packer_ancho_param_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned RATIO = 4
) ();
    logic [IN_W-1:0]       data_in;
    logic                  valid_in;
    logic                  ready_in;
    logic                  flush;
    logic [IN_W*RATIO-1:0] data_out;
    logic [RATIO-1:0]      keep_out;
    logic                  valid_out;
    logic                  ready_out;

    // Source and sink side (drives beats, flush and downstream ready).
    modport master (
        output data_in, valid_in, flush, ready_out,
        input  ready_in, data_out, keep_out, valid_out
    );

    // Packer side.
    modport slave (
        input  data_in, valid_in, flush, ready_out,
        output ready_in, data_out, keep_out, valid_out
    );
endinterface

// File: rtl/packer_ancho_param.sv
// Narrow-to-wide word packer: gathers RATIO beats of IN_W bits into one word, with
// selectable lane order, output backpressure and flush of a partial word plus keep mask.
module packer_ancho_param #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned RATIO     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic              clk_4f,
    input logic              reset,
    packer_ancho_param_if.slave bus
);
    localparam int unsigned      OUT_W = IN_W * RATIO;
    localparam int unsigned      CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] acc_q;
    logic [RATIO-1:0] acc_keep_q;
    logic [OUT_W-1:0] data_q;
    logic [RATIO-1:0] keep_q;
    logic             valid_q;

    logic             slot_free;
    logic             ready_int;
    logic             acc_beat;
    logic             complete;
    logic [CNT_W-1:0] lane_sel;
    logic [OUT_W-1:0] acc_d;
    logic [RATIO-1:0] keep_d;

    // Handshake decode, lane selection and merge of the incoming beat into the accumulator.
    always_comb begin
        slot_free = !valid_q | bus.ready_out;
        // Only the completing beat needs a free output slot.
        ready_int = (cnt_q != LAST) | slot_free;
        acc_beat  = bus.valid_in & ready_int;
        lane_sel  = MSB_FIRST ? (LAST - cnt_q) : cnt_q;
        acc_d     = acc_q;
        keep_d    = acc_keep_q;
        if (acc_beat) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (lane_sel == CNT_W'(i)) begin
                    acc_d[i*IN_W +: IN_W] = bus.data_in;
                    keep_d[i]             = 1'b1;
                end
            end
        end
        // Full word on the last beat, or a flush closing a non-empty word (beat in this
        // cycle counts). A flush without a free slot is ignored; the source holds it.
        complete = (acc_beat & (cnt_q == LAST)) |
                   (bus.flush & slot_free & ((cnt_q != '0) | acc_beat));
    end

    // Accumulator, beat counter and output register with hold under backpressure.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            valid_q    <= 1'b0;
        end else if (complete) begin
            data_q     <= acc_d;
            keep_q     <= keep_d;
            valid_q    <= 1'b1;
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
        end else begin
            if (valid_q & bus.ready_out) begin
                valid_q <= 1'b0;
            end
            if (acc_beat) begin
                acc_q      <= acc_d;
                acc_keep_q <= keep_d;
                cnt_q      <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.ready_in  = ready_int;
    assign bus.data_out  = data_q;
    assign bus.keep_out  = keep_q;
    assign bus.valid_out = valid_q;
endmodule
